// File: rtl/mole_pkg.sv
// Shared constants for the whack-a-mole button path.
package mole_pkg;

    // Number of mole buttons; fixes the width of every button bus.
    localparam int N_BTN = 8;

    // Value of the active-low button bus when no press pulse is present.
    localparam logic [N_BTN-1:0] BTN_IDLE = 8'hFF;

    // 10 ms of stable level at CLK_HZ before a level is accepted.
    localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;

    // Debounce counter width; 2**CNT_W_DEFAULT must exceed DEBOUNCE_CYC_DEFAULT.
    localparam int CNT_W_DEFAULT = 20;

    localparam int CLK_HZ = 100_000_000;

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-FF synchroniser, counter debounce and press-edge detect.
// All levels are active-low (0 = pressed); press is an active-high
// one-cycle strobe on the cycle the debounced level falls.
module debounce_bit
    import mole_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic held_n,
    output logic press
);

    // Terminal count: the mismatch that finds the counter here is the
    // DEBOUNCE_CYC-th consecutive one and gets the new level accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             held_q,  held_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state: synchroniser shift, debounce count/accept, press edge.
    always_comb begin
        sync1_d = raw_n;
        sync2_d = sync1_q;
        held_d  = held_q;
        cnt_d   = '0;
        if (sync2_q != held_q) begin
            if (cnt_q == CNT_LAST) begin
                held_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Only the 1->0 transition of the debounced level is a press;
        // releases just move held.
        press_d = held_q & ~held_d;
    end

    // State registers; reset parks everything in the released state so a
    // button held through reset must debounce again from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            held_q  <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign held_n = held_q;
    assign press  = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the active-low mole pad inputs into the one-cycle active-low
// press pulse bus consumed by the LED/scoring stage.
// DEBOUNCE_CYC must be >= 1 and 2**CNT_W must exceed DEBOUNCE_CYC.
module button_conditioner
    import mole_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button_raw,
    output logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] held,
    output logic             press_any
);

    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] button_q, button_d;
    logic             press_any_q, press_any_d;

    // Buttons are fully independent; simultaneous accepts share one pulse cycle.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw_n  (button_raw[i]),
            .held_n (held[i]),
            .press  (press_vec[i])
        );
    end

    // Output bus is active-low; press_any flags any pulse in the same cycle.
    always_comb begin
        button_d    = ~press_vec;
        press_any_d = |press_vec;
    end

    // Registered outputs so the downstream stage sees glitch-free pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            button_q    <= BTN_IDLE;
            press_any_q <= 1'b0;
        end else begin
            button_q    <= button_d;
            press_any_q <= press_any_d;
        end
    end

    assign button    = button_q;
    assign press_any = press_any_q;

endmodule
